// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI Stream sources share one sink.
// A grant is held until the granted source's tlast beat is accepted; every output beat carries its source index.
module axis_rr_arbiter #(
   parameter  int NUM_PORTS   = 4,
   parameter  int DATA_WIDTH  = 8,
   parameter  int TUSER_WIDTH = 1,
   localparam int ID_WIDTH    = $clog2(NUM_PORTS)
) (
   input  logic                             clk_i,
   input  logic                             arstn_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata_i,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid_i,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast_i,
   input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser_i,
   output logic [NUM_PORTS-1:0]             s_axis_tready_o,
   input  logic                             m_axis_tready_i,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata_o,
   output logic                             m_axis_tvalid_o,
   output logic                             m_axis_tlast_o,
   output logic [TUSER_WIDTH-1:0]           m_axis_tuser_o,
   output logic [ID_WIDTH-1:0]              m_axis_tid_o,
   output logic                             busy_o
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t              r_state;
   logic [ID_WIDTH-1:0] r_grant;
   logic [ID_WIDTH-1:0] r_last;

   logic                w_found;
   logic [ID_WIDTH-1:0] w_winner;
   logic [ID_WIDTH-1:0] w_cand;
   logic                w_release;

   // Round-robin search starting one past the previous winner, wrapping modulo NUM_PORTS.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         w_cand = ID_WIDTH'((int'(r_last) + k) % NUM_PORTS);
         if (!w_found && s_axis_tvalid_i[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // Handshake: a beat moves on a rising edge where valid and ready are both high; the
   // sink's ready is routed only to the granted source, all other sources see ready low.
   always_comb begin
      m_axis_tvalid_o = 1'b0;
      m_axis_tdata_o  = '0;
      m_axis_tuser_o  = '0;
      m_axis_tlast_o  = 1'b0;
      m_axis_tid_o    = '0;
      s_axis_tready_o = '0;
      if (r_state == ST_BUSY) begin
         m_axis_tvalid_o          = s_axis_tvalid_i[r_grant];
         m_axis_tdata_o           = s_axis_tdata_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tuser_o           = s_axis_tuser_i[r_grant*TUSER_WIDTH +: TUSER_WIDTH];
         m_axis_tlast_o           = s_axis_tlast_i[r_grant];
         m_axis_tid_o             = r_grant;
         s_axis_tready_o[r_grant] = m_axis_tready_i;
      end
   end

   assign w_release = m_axis_tvalid_o & m_axis_tready_i & m_axis_tlast_o;
   assign busy_o    = (r_state == ST_BUSY);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= ID_WIDTH'(NUM_PORTS - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= w_winner;
                  r_last  <= w_winner;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_release) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
